muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//   Iterative RV32M multiply/divide unit, the multi-cycle companion to the single-cycle ALU decode/execute path.
//   Decodes funct3 for MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and computes 1 bit per cycle.
//   Sits in EX beside the ALU; the core stalls on in_ready/out_valid handshakes.
// PARAMETERS
//   XLEN       32   operand/result width (>=8, even)
//   CNT_W      $clog2(XLEN)+1   iteration counter width (derived, not overridden)
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operation request
//   in_ready   out  1      unit can accept a request (IDLE)
//   funct3     in   3      RV32M op select (000 MUL .. 111 REMU)
//   op_a       in   XLEN   rs1 value
//   op_b       in   XLEN   rs2 value
//   flush      in   1      synchronous kill of in-flight op
//   out_valid  out  1      result available
//   out_ready  in   1      consumer takes result
//   result     out  XLEN   rd value
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, result=0, counter=0, all datapath regs 0.
//   States: IDLE -> BUSY -> DONE -> IDLE; IDLE -> DONE directly on fast path.
//   IDLE: in_ready=1. Accept when in_valid&&in_ready at edge T0: latch funct3, operand magnitudes, result signs.
//     Signedness: MUL/MULH/DIV/REM both signed; MULHSU a signed, b unsigned; MULHU/DIVU/REMU unsigned.
//   Fast path (decided at accept, goes straight to DONE, out_valid at T0+1):
//     DIV/DIVU/REM/REMU with op_b==0: quotient = all ones, remainder = op_a.
//     DIV/REM with op_a==2^(XLEN-1), op_b==all ones: quotient = op_a, remainder = 0.
//   BUSY: exactly XLEN cycles, counter XLEN-1 downto 0.
//     MUL*: shift-add on magnitudes into 2*XLEN product register.
//     DIV*: restoring divide, 1 quotient bit/cycle, XLEN-bit remainder plus 1 guard bit.
//     On counter==0: apply sign fix (negate product if signs differ; quotient sign = sa^sb; remainder sign = sa), go DONE.
//     Normal latency: out_valid first high at T0+XLEN+1.
//   Result select: MUL low XLEN; MULH/MULHSU/MULHU high XLEN; DIV/DIVU quotient; REM/REMU remainder.
//   DONE: out_valid=1, result stable; held until out_valid&&out_ready, then IDLE (in_ready=1 next cycle).
//     No accept in the same cycle as result handoff (in_ready=0 in DONE).
//   flush: any state -> IDLE next edge, out_valid=0, in-flight result discarded; flush beats in_valid same cycle (no accept).
//   Illegal funct3 does not exist (all 8 codes defined).
//   result holds last value after handoff until the next DONE; only out_valid qualifies it.
//   Reset mid-operation: immediate return to reset values; no partial result ever appears.
// TESTING
//   MUL 7*(-3), out_ready=1 -> out_valid at T0+33, result=0xFFFFFFEB; in_ready back high one cycle later.
//   MULHU 0xFFFFFFFF*0xFFFFFFFF -> result=0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU -> 0xFFFFFFFF.
//   DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//   DIVU 5/0 -> 0xFFFFFFFF at T0+1; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
//   Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and result stable, in_valid ignored; release -> single handoff.
//   flush at BUSY cycle 5, then rst_n pulse mid-BUSY of new op -> no out_valid, state IDLE, all outputs at reset values.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Divide-by-zero and signed overflow bypass the iteration and complete one cycle after accept.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
        return ~v + XLEN'(1);
    endfunction

    state_e              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic                neg_res_q, neg_res_d;
    logic                neg_rem_q, neg_rem_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*XLEN-1:0]   prod_q, prod_d;
    logic [XLEN:0]       rem_q, rem_d;
    logic [XLEN-1:0]     quo_q, quo_d;
    logic [XLEN-1:0]     result_q, result_d;

    // Request decode: signedness, magnitudes and fast-path detection
    logic            is_div, signed_a, signed_b, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, fast;
    logic [XLEN-1:0] fast_res;

    always_comb begin
        is_div   = funct3[2];
        signed_a = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        signed_b = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg    = signed_a && op_a[XLEN-1];
        b_neg    = signed_b && op_b[XLEN-1];
        a_mag    = a_neg ? negate(op_a) : op_a;
        b_mag    = b_neg ? negate(op_b) : op_b;
        div_zero = is_div && (op_b == '0);
        div_ovf  = is_div && !funct3[0] && (op_a == MinInt) && (op_b == '1);
        fast     = div_zero || div_ovf;
        if (funct3[1]) begin
            fast_res = div_zero ? op_a : '0;
        end else begin
            fast_res = div_zero ? '1 : op_a;
        end
    end

    // One iteration of each datapath, plus the sign-corrected final result
    logic [XLEN:0]       mul_acc, rem_shift, rem_diff, rem_step;
    logic [2*XLEN-1:0]   prod_step, prod_fix;
    logic [XLEN-1:0]     quo_step, quo_fix, rem_fix, final_res;

    always_comb begin
        mul_acc   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, b_q} : '0);
        prod_step = {mul_acc, prod_q[XLEN-1:1]};
        rem_shift = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
        rem_diff  = rem_shift - {1'b0, b_q};
        // Borrow out of the guard bit means the trial subtraction failed: restore
        rem_step  = rem_diff[XLEN] ? rem_shift : rem_diff;
        quo_step  = {quo_q[XLEN-2:0], ~rem_diff[XLEN]};
        prod_fix  = neg_res_q ? (~prod_step + (2*XLEN)'(1)) : prod_step;
        quo_fix   = neg_res_q ? negate(quo_step) : quo_step;
        rem_fix   = neg_rem_q ? negate(rem_step[XLEN-1:0]) : rem_step[XLEN-1:0];
        case (op_q)
            3'b000:                 final_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res = quo_fix;
            default:                final_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        b_d       = b_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        result_d  = result_q;
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);

        if (flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        op_d      = funct3;
                        b_d       = b_mag;
                        neg_res_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        prod_d    = {{XLEN{1'b0}}, a_mag};
                        quo_d     = a_mag;
                        rem_d     = '0;
                        if (fast) begin
                            result_d = fast_res;
                            state_d  = StDone;
                        end else begin
                            cnt_d   = CNT_W'(XLEN - 1);
                            state_d = StBusy;
                        end
                    end
                end
                StBusy: begin
                    prod_d = prod_step;
                    rem_d  = rem_step;
                    quo_d  = quo_step;
                    if (cnt_q == '0) begin
                        result_d = final_res;
                        state_d  = StDone;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            op_q      <= '0;
            b_q       <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            prod_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            b_q       <= b_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            cnt_q     <= cnt_d;
            prod_q    <= prod_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            result_q  <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, randomized ops against an
// arithmetic reference model, and hand-written backpressure / flush / reset sequences.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  funct3 = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;

    int n_vec = 0;
    int n_err = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3    (funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Reference model straight from the RV32M rules using 64-bit arithmetic
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] ua, ub, p;
        int          ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        ia = a;
        ib = b;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return 33;
    endfunction

    // Issue one op with out_ready=1; latency k means out_valid sampled high k edges after accept
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        @(negedge clk);
        check("in_ready_before_issue", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        funct3    = f;
        op_a      = a;
        op_b      = b;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        res = result;
        @(negedge clk);
        check("in_ready_after_handoff", 32'(in_ready), 32'd1);
        check("out_valid_after_handoff", 32'(out_valid), 32'd0);
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t        vecs[16];
    logic [31:0] res;
    int          lat;
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    logic        seen;

    initial begin
        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 33};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        33};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         33};
        vecs[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1};
        vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1};
        vecs[12] = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[13] = '{3'd7, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 33};
        vecs[14] = '{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         33};
        vecs[15] = '{3'd2, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 33};

        // Reset state
        #3;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result", result, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, res, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        for (int i = 0; i < 300; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom();
            rb = $urandom();
            case ($urandom_range(0, 9))
                0: rb = 32'h0;
                1: rb = 32'($urandom_range(1, 15));
                2: begin rb = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) ra = 32'h8000_0000; end
                3: ra = 32'($urandom_range(0, 255));
                default: ;
            endcase
            run_op(rf, ra, rb, res, lat);
            check($sformatf("rand%0d_f%0d_%h_%h_result", i, rf, ra, rb), res, model(rf, ra, rb));
            check($sformatf("rand%0d_latency", i), 32'(lat), 32'(model_lat(rf, ra, rb)));
        end

        // Backpressure: DONE holds under out_ready=0 and ignores new requests
        @(negedge clk);
        in_valid  = 1'b1;
        funct3    = 3'd5;
        op_a      = 32'd100;
        op_b      = 32'd7;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("bp_latency", 32'(lat), 32'd33);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            funct3   = 3'd5;
            op_a     = 32'd9;
            op_b     = 32'd0;
            @(negedge clk);
            check("bp_out_valid_held", 32'(out_valid), 32'd1);
            check("bp_result_held", result, 32'd14);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_result_after_handoff", result, 32'd14);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_single_handoff", 32'(out_valid), 32'd0);
            check("bp_idle_in_ready", 32'(in_ready), 32'd1);
        end

        // Flush at BUSY cycle 5 discards the op
        in_valid = 1'b1;
        funct3   = 3'd0;
        op_a     = 32'd123;
        op_b     = 32'd456;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        check("flush_pre_busy", 32'(in_ready), 32'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_in_ready", 32'(in_ready), 32'd1);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("flush_no_result", 32'(seen), 32'd0);

        // flush wins over a same-cycle request (a fast op would otherwise complete next edge)
        flush    = 1'b1;
        in_valid = 1'b1;
        funct3   = 3'd5;
        op_a     = 32'd5;
        op_b     = 32'd0;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_beats_valid_in_ready", 32'(in_ready), 32'd1);
        check("flush_beats_valid_out_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-BUSY
        @(negedge clk);
        in_valid = 1'b1;
        funct3   = 3'd0;
        op_a     = 32'd77;
        op_b     = 32'd88;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) @(negedge clk);
        check("rst_pre_busy", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("rst_no_result", 32'(seen), 32'd0);
        check("rst_final_in_ready", 32'(in_ready), 32'd1);
        check("rst_final_result", result, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
